wdt_multi: RTL and testbench
============================

# wdt_multi

Parametrised multi-channel watchdog timer for the system WDT slot. It provides N_CH independent watchdog channels that share one prescaler. Each channel supports optional windowed kicking and a two-stage timeout: a first-stage interrupt, then a second-stage reset request. It sits behind the WDT register slave and drives the CPU interrupt lines and the system reset request.

## Interface
- N_CH, 4: number of watchdog channels (1..8)
- CNT_W, 32: width of the per-channel counter, TOCNT and WIN
- PRE_W, 16: width of the shared prescaler
- KICK_KEY, 32'h5A5A_A5A5: magic value that a KICK write must carry
- wdt_clk  in  1  single block clock
- wdt_rst  in  1  asynchronous, active-low reset
- reg_we  in  1  one-cycle register write strobe
- reg_ch  in  $clog2(N_CH)  target channel (ignored for sel PRESC)
- reg_sel  in  3  register select: CTRL=0, TOCNT=1, WIN=2, KICK=3, STATUS=4 (read-only), PRESC=5
- reg_wdata  in  CNT_W  write data
- reg_rdata  out  CNT_W  combinational read of {reg_ch, reg_sel}; KICK reads 0
- irq  out  N_CH  registered first-stage timeout interrupt, one bit per channel
- rst_req  out  1  registered OR of all channels in FIRED

## Operation
- CTRL bits: [0] en, [1] win_en, [2] stage2_en.
- STATUS bits: [1:0] state, [2] early, [3] bad_key.
- Prescaler: pre_cnt is free-running. tick = (pre_cnt == PRESC), and pre_cnt wraps to 0 on tick. A PRESC write clears pre_cnt. PRESC=0 gives a tick every cycle.
- Channel FSM states: IDLE, COUNT, STAGE1, FIRED.
  - IDLE -> COUNT on a CTRL write with en=1; cnt <= 0.
  - COUNT: on tick, if cnt == TOCNT, go to STAGE1 with cnt <= 0; otherwise cnt++.
  - STAGE1: irq is high. On tick, if stage2_en and cnt == TOCNT, go to FIRED. If stage2_en=0, cnt holds and the channel stays in STAGE1.
  - FIRED: irq and rst_req are high. The state is sticky and exits only through en=0 or wdt_rst.
  - Any state -> IDLE on a CTRL write with en=0. This clears cnt, early and the channel's irq and rst_req contribution.
- Kick: a KICK write with reg_wdata == KICK_KEY.
  - In COUNT: if win_en and cnt < WIN, set early and go to FIRED. Otherwise cnt <= 0.
  - In STAGE1: go to COUNT with cnt <= 0; irq drops.
  - In IDLE or FIRED: no effect.
  - A wrong key is ignored and sets bad_key.
- early and bad_key are sticky; they clear on a CTRL write.
- Simultaneous kick and timeout tick in the same cycle: the kick wins.
- TOCNT and WIN writes take effect immediately on the next compare. TOCNT=0 times out on the first tick.
- cnt saturates at its maximum and never wraps. With TOCNT=max, the compare still fires.

## Timing
- All outputs are registered. Reset values: irq=0, rst_req=0, every state=IDLE, cnt=0, pre_cnt=0, PRESC=0, CTRL/TOCNT/WIN=0, early=0, bad_key=0.
- A write is sampled on the wdt_clk edge where reg_we=1. Its effect is visible on the outputs after that edge; there is no wait state.
- Timeout latency: TOCNT+1 ticks after the enabling edge or the last kick, irq rises on the edge of the timeout tick.
  - With PRESC=0 and TOCNT=3, irq is high 4 cycles after the enable edge.
- rst_req rises on the edge where FIRED is entered: 2*(TOCNT+1) ticks after enable without kicks, or the kick edge itself for an early violation.
- wdt_rst deasserting mid-count restarts everything from the reset values. An asynchronous assert clears irq and rst_req immediately.

## Structure
- Package wdt_pkg holds:
  - the wdt_state_e enum {IDLE, COUNT, STAGE1, FIRED}
  - the reg_sel encodings
  - the CTRL and STATUS bit-index constants
  - the default KICK_KEY
- Sub-module wdt_channel (one FSM, cnt, CTRL, TOCNT, WIN and sticky flags) is instantiated N_CH times in a generate loop.
- The wdt_multi top holds the prescaler, write decode, read mux and the rst_req OR.

## Test plan
- Basic timeout: PRESC=0, ch0 TOCNT=3, en=1 -> irq[0] rises 4 cycles after the enable edge; other irq bits stay 0.
- Prescaler: PRESC=4, TOCNT=1 -> irq[0] rises 10 cycles after enable.
- Kicking and stage 2: TOCNT=7; kick every 5 cycles for 100 cycles -> irq stays 0. Then stop kicking with stage2_en=1 -> irq at +8 cycles and rst_req at +16 cycles; STATUS.state reads FIRED.
- Window: win_en=1, WIN=5, TOCNT=9; kick at cnt=2 -> rst_req next edge and STATUS.early=1. A kick at cnt=6 -> cnt reset, no rst_req.
- Bad key and simultaneous events: a kick with 0x12345678 -> bad_key=1 and the timeout still fires. A valid kick on the exact timeout tick -> no irq.
- Disable and reset: en=0 written during FIRED -> rst_req and irq drop next edge. Assert wdt_rst mid-count on 2 channels -> all outputs 0 immediately and all registers back to reset values.

Source files
------------

// File: rtl/wdt_pkg.sv
// Shared types and encodings for the multi-channel watchdog.
package wdt_pkg;

  // Channel FSM states; the encoding is what STATUS[1:0] reports.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    STAGE1 = 2'd2,
    FIRED  = 2'd3
  } wdt_state_e;

  // Register select encodings.
  localparam logic [2:0] SEL_CTRL   = 3'd0;
  localparam logic [2:0] SEL_TOCNT  = 3'd1;
  localparam logic [2:0] SEL_WIN    = 3'd2;
  localparam logic [2:0] SEL_KICK   = 3'd3;
  localparam logic [2:0] SEL_STATUS = 3'd4;
  localparam logic [2:0] SEL_PRESC  = 3'd5;

  // CTRL bit positions.
  localparam int CTRL_W         = 3;
  localparam int CTRL_EN        = 0;
  localparam int CTRL_WIN_EN    = 1;
  localparam int CTRL_STAGE2_EN = 2;

  // STATUS bit positions.
  localparam int STAT_W       = 4;
  localparam int STAT_EARLY   = 2;
  localparam int STAT_BAD_KEY = 3;

  localparam logic [31:0] KICK_KEY_DEFAULT = 32'h5A5A_A5A5;

  // Packs the STATUS word from a channel's state and sticky flags.
  function automatic logic [STAT_W-1:0] pack_status(wdt_state_e st, logic early, logic bad_key);
    logic [STAT_W-1:0] s;
    s               = '0;
    s[1:0]          = st;
    s[STAT_EARLY]   = early;
    s[STAT_BAD_KEY] = bad_key;
    return s;
  endfunction

endpackage

// File: rtl/wdt_channel.sv
// One watchdog channel: FSM, saturating counter, its config registers and sticky flags.
module wdt_channel
  import wdt_pkg::*;
#(
  parameter int               CNT_W    = 32,
  parameter logic [CNT_W-1:0] KICK_KEY = CNT_W'(KICK_KEY_DEFAULT)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              tick_i,
  input  logic              ctrl_we_i,
  input  logic              tocnt_we_i,
  input  logic              win_we_i,
  input  logic              kick_we_i,
  input  logic [CNT_W-1:0]  wdata_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [CNT_W-1:0]  tocnt_o,
  output logic [CNT_W-1:0]  win_o,
  output logic [STAT_W-1:0] status_o,
  output logic              irq_o,
  output logic              fired_d_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  wdt_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  tocnt_q, tocnt_d;
  logic [CNT_W-1:0]  win_q, win_d;
  logic              early_q, early_d;
  logic              bad_key_q, bad_key_d;
  logic              irq_q, irq_d;

  logic             kick_ok;
  logic             kick_bad;
  logic [CNT_W-1:0] cnt_inc;

  assign kick_ok  = kick_we_i && (wdata_i == KICK_KEY);
  assign kick_bad = kick_we_i && (wdata_i != KICK_KEY);
  // The counter sticks at its maximum so a TOCNT of all-ones still matches.
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state logic: a kick beats a same-cycle tick, a CTRL write beats both.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    tocnt_d   = tocnt_q;
    win_d     = win_q;
    early_d   = early_q;
    bad_key_d = bad_key_q;
    if (tocnt_we_i) tocnt_d = wdata_i;
    if (win_we_i)   win_d   = wdata_i;
    case (state_q)
      COUNT: begin
        if (kick_ok) begin
          if (ctrl_q[CTRL_WIN_EN] && (cnt_q < win_q)) begin
            early_d = 1'b1;
            state_d = FIRED;
          end else begin
            cnt_d = '0;
          end
        end else if (tick_i) begin
          if (cnt_q == tocnt_q) begin
            state_d = STAGE1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      STAGE1: begin
        if (kick_ok) begin
          state_d = COUNT;
          cnt_d   = '0;
        end else if (tick_i && ctrl_q[CTRL_STAGE2_EN]) begin
          if (cnt_q == tocnt_q) state_d = FIRED;
          else                  cnt_d   = cnt_inc;
        end
      end
      default: ;
    endcase
    if (kick_bad) bad_key_d = 1'b1;
    if (ctrl_we_i) begin
      ctrl_d    = wdata_i[CTRL_W-1:0];
      early_d   = 1'b0;
      bad_key_d = 1'b0;
      if (!wdata_i[CTRL_EN]) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (state_q == IDLE) begin
        state_d = COUNT;
        cnt_d   = '0;
      end
    end
    irq_d = (state_d == STAGE1) || (state_d == FIRED);
  end

  // State and configuration registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ctrl_q    <= '0;
      tocnt_q   <= '0;
      win_q     <= '0;
      early_q   <= 1'b0;
      bad_key_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      tocnt_q   <= tocnt_d;
      win_q     <= win_d;
      early_q   <= early_d;
      bad_key_q <= bad_key_d;
      irq_q     <= irq_d;
    end
  end

  assign ctrl_o    = ctrl_q;
  assign tocnt_o   = tocnt_q;
  assign win_o     = win_q;
  assign status_o  = pack_status(state_q, early_q, bad_key_q);
  assign irq_o     = irq_q;
  assign fired_d_o = (state_d == FIRED);

endmodule

// File: rtl/wdt_multi.sv
// Multi-channel watchdog: shared prescaler, register decode/readback, reset request.
module wdt_multi
  import wdt_pkg::*;
#(
  parameter int               N_CH     = 4,
  parameter int               CNT_W    = 32,
  parameter int               PRE_W    = 16,
  parameter logic [CNT_W-1:0] KICK_KEY = CNT_W'(KICK_KEY_DEFAULT),
  localparam int              CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             wdt_clk,
  input  logic             wdt_rst,
  input  logic             reg_we,
  input  logic [CH_W-1:0]  reg_ch,
  input  logic [2:0]       reg_sel,
  input  logic [CNT_W-1:0] reg_wdata,
  output logic [CNT_W-1:0] reg_rdata,
  output logic [N_CH-1:0]  irq,
  output logic             rst_req
);

  // Register access: reg_we is a single-cycle strobe, always accepted on the
  // edge where it is high (no back-pressure); reads are combinational on
  // {reg_ch, reg_sel} and need no strobe.

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic             tick;
  logic             presc_we;
  logic             rst_req_q;

  logic [CTRL_W-1:0] ctrl_a   [N_CH];
  logic [CNT_W-1:0]  tocnt_a  [N_CH];
  logic [CNT_W-1:0]  win_a    [N_CH];
  logic [STAT_W-1:0] status_a [N_CH];
  logic [N_CH-1:0]   fired_d;

  assign tick     = (pre_cnt_q == presc_q);
  assign presc_we = reg_we && (reg_sel == SEL_PRESC);

  // Prescaler next state: wrap on tick, restart whenever PRESC is rewritten.
  always_comb begin
    pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
    presc_d   = presc_q;
    if (presc_we) begin
      presc_d   = reg_wdata[PRE_W-1:0];
      pre_cnt_d = '0;
    end
  end

  // Prescaler and reset-request registers.
  always_ff @(posedge wdt_clk or negedge wdt_rst) begin
    if (!wdt_rst) begin
      pre_cnt_q <= '0;
      presc_q   <= '0;
      rst_req_q <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      presc_q   <= presc_d;
      rst_req_q <= |fired_d;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic hit;
    assign hit = reg_we && (reg_ch == CH_W'(g));

    wdt_channel #(
      .CNT_W    (CNT_W),
      .KICK_KEY (KICK_KEY)
    ) u_ch (
      .clk_i      (wdt_clk),
      .rst_ni     (wdt_rst),
      .tick_i     (tick),
      .ctrl_we_i  (hit && (reg_sel == SEL_CTRL)),
      .tocnt_we_i (hit && (reg_sel == SEL_TOCNT)),
      .win_we_i   (hit && (reg_sel == SEL_WIN)),
      .kick_we_i  (hit && (reg_sel == SEL_KICK)),
      .wdata_i    (reg_wdata),
      .ctrl_o     (ctrl_a[g]),
      .tocnt_o    (tocnt_a[g]),
      .win_o      (win_a[g]),
      .status_o   (status_a[g]),
      .irq_o      (irq[g]),
      .fired_d_o  (fired_d[g])
    );
  end

  // Readback mux; PRESC ignores reg_ch, out-of-range channels read zero.
  always_comb begin
    reg_rdata = '0;
    if (reg_sel == SEL_PRESC) begin
      reg_rdata = CNT_W'(presc_q);
    end else if (int'(reg_ch) < N_CH) begin
      case (reg_sel)
        SEL_CTRL:   reg_rdata = CNT_W'(ctrl_a[reg_ch]);
        SEL_TOCNT:  reg_rdata = tocnt_a[reg_ch];
        SEL_WIN:    reg_rdata = win_a[reg_ch];
        SEL_STATUS: reg_rdata = CNT_W'(status_a[reg_ch]);
        default:    reg_rdata = '0;
      endcase
    end
  end

  assign rst_req = rst_req_q;

endmodule

// File: tb/tb_wdt_multi.sv
// Bench for wdt_multi: vector table for the basic path, directed sequences for the timing corners.
module tb_wdt_multi;
  import wdt_pkg::*;

  localparam logic [31:0] KEY = 32'h5A5A_A5A5;
  localparam logic [31:0] BAD = 32'h1234_5678;

  logic        wdt_clk = 1'b0;
  logic        wdt_rst = 1'b0;
  logic        reg_we = 1'b0;
  logic [1:0]  reg_ch = '0;
  logic [2:0]  reg_sel = '0;
  logic [31:0] reg_wdata = '0;
  logic [31:0] reg_rdata;
  logic [3:0]  irq;
  logic        rst_req;

  int n_checks = 0;
  int n_errors = 0;

  wdt_multi #(.N_CH(4), .CNT_W(32), .PRE_W(16), .KICK_KEY(KEY)) dut (
    .wdt_clk   (wdt_clk),
    .wdt_rst   (wdt_rst),
    .reg_we    (reg_we),
    .reg_ch    (reg_ch),
    .reg_sel   (reg_sel),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .irq       (irq),
    .rst_req   (rst_req)
  );

  // Clock
  always #5 wdt_clk = ~wdt_clk;

  typedef struct {
    logic        we;
    logic [1:0]  ch;
    logic [2:0]  sel;
    logic [31:0] wdata;
    logic [3:0]  exp_irq;
    logic        exp_rst;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] ch, input logic [2:0] sel, input logic [31:0] d);
    reg_we    = 1'b1;
    reg_ch    = ch;
    reg_sel   = sel;
    reg_wdata = d;
    @(posedge wdt_clk);
    #1;
    reg_we    = 1'b0;
    reg_wdata = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge wdt_clk);
      #1;
    end
  endtask

  task automatic rd_check(input string name, input logic [1:0] ch, input logic [2:0] sel,
                          input logic [31:0] exp);
    reg_ch  = ch;
    reg_sel = sel;
    #1;
    check(name, reg_rdata, exp);
  endtask

  task automatic chk_out(input string name, input logic [3:0] e_irq, input logic e_rst);
    check({name, "_irq"}, 32'(irq), 32'(e_irq));
    check({name, "_rst_req"}, 32'(rst_req), 32'(e_rst));
  endtask

  initial begin
    logic [3:0] irq_acc;

    // Basic timeout on ch0 with PRESC=0, TOCNT=3, plus readback/isolation.
    vecs[0]  = '{1'b1, 2'd0, SEL_TOCNT,  32'd3,  4'b0000, 1'b0, 32'd3};
    vecs[1]  = '{1'b1, 2'd0, SEL_CTRL,   32'd1,  4'b0000, 1'b0, 32'd1};
    vecs[2]  = '{1'b0, 2'd0, SEL_STATUS, 32'd0,  4'b0000, 1'b0, 32'd1};
    vecs[3]  = '{1'b0, 2'd0, SEL_STATUS, 32'd0,  4'b0000, 1'b0, 32'd1};
    vecs[4]  = '{1'b0, 2'd0, SEL_STATUS, 32'd0,  4'b0000, 1'b0, 32'd1};
    vecs[5]  = '{1'b0, 2'd0, SEL_STATUS, 32'd0,  4'b0001, 1'b0, 32'd2};
    vecs[6]  = '{1'b0, 2'd0, SEL_STATUS, 32'd0,  4'b0001, 1'b0, 32'd2};
    vecs[7]  = '{1'b0, 2'd1, SEL_STATUS, 32'd0,  4'b0001, 1'b0, 32'd0};
    vecs[8]  = '{1'b1, 2'd0, SEL_CTRL,   32'd0,  4'b0000, 1'b0, 32'd0};
    vecs[9]  = '{1'b1, 2'd1, SEL_WIN,    32'h55, 4'b0000, 1'b0, 32'h55};
    vecs[10] = '{1'b0, 2'd0, SEL_WIN,    32'd0,  4'b0000, 1'b0, 32'd0};
    vecs[11] = '{1'b0, 2'd1, SEL_KICK,   32'd0,  4'b0000, 1'b0, 32'd0};
    vecs[12] = '{1'b1, 2'd1, SEL_WIN,    32'd0,  4'b0000, 1'b0, 32'd0};

    // Reset
    wdt_rst = 1'b0;
    repeat (2) @(posedge wdt_clk);
    #1;
    chk_out("in_reset", 4'b0000, 1'b0);
    @(negedge wdt_clk);
    wdt_rst = 1'b1;
    @(posedge wdt_clk);
    #1;
    chk_out("after_reset", 4'b0000, 1'b0);
    rd_check("reset_status0", 2'd0, SEL_STATUS, 32'd0);
    rd_check("reset_presc",   2'd0, SEL_PRESC,  32'd0);
    rd_check("reset_tocnt3",  2'd3, SEL_TOCNT,  32'd0);

    // Vector table
    for (int i = 0; i < 13; i++) begin
      reg_we    = vecs[i].we;
      reg_ch    = vecs[i].ch;
      reg_sel   = vecs[i].sel;
      reg_wdata = vecs[i].wdata;
      @(posedge wdt_clk);
      #1;
      reg_we    = 1'b0;
      reg_wdata = '0;
      check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
      check($sformatf("vec%0d_rst_req", i), 32'(rst_req), 32'(vecs[i].exp_rst));
      check($sformatf("vec%0d_rdata", i), reg_rdata, vecs[i].exp_rdata);
    end

    // Prescaler: PRESC=4, TOCNT=1, enable aligned with a tick -> irq 10 cycles later.
    wr(2'd0, SEL_TOCNT, 32'd1);
    wr(2'd0, SEL_PRESC, 32'd4);
    idle(4);
    wr(2'd0, SEL_CTRL, 32'd1);
    idle(9);
    chk_out("presc_before", 4'b0000, 1'b0);
    idle(1);
    chk_out("presc_fire", 4'b0001, 1'b0);
    rd_check("presc_read",     2'd0, SEL_PRESC, 32'd4);
    rd_check("presc_read_ch3", 2'd3, SEL_PRESC, 32'd4);
    wr(2'd0, SEL_CTRL, 32'd0);
    wr(2'd0, SEL_PRESC, 32'd0);

    // Kicking keeps irq low; then stage 2 fires.
    wr(2'd0, SEL_TOCNT, 32'd7);
    wr(2'd0, SEL_CTRL, 32'd5);
    irq_acc = '0;
    for (int k = 0; k < 20; k++) begin
      repeat (4) begin
        idle(1);
        irq_acc |= irq;
      end
      wr(2'd0, SEL_KICK, KEY);
      irq_acc |= irq;
    end
    check("kick_hold_irq", 32'(irq_acc), 32'd0);
    idle(7);
    chk_out("s2_pre_irq", 4'b0000, 1'b0);
    idle(1);
    chk_out("s2_irq", 4'b0001, 1'b0);
    idle(7);
    chk_out("s2_pre_fire", 4'b0001, 1'b0);
    idle(1);
    chk_out("s2_fire", 4'b0001, 1'b1);
    rd_check("s2_status", 2'd0, SEL_STATUS, 32'd3);
    idle(3);
    chk_out("s2_sticky", 4'b0001, 1'b1);
    wr(2'd0, SEL_CTRL, 32'd0);
    chk_out("fired_disable", 4'b0000, 1'b0);

    // Window: early kick fires immediately, late kick restarts the count.
    wr(2'd0, SEL_WIN, 32'd5);
    wr(2'd0, SEL_TOCNT, 32'd9);
    wr(2'd0, SEL_CTRL, 32'd3);
    idle(2);
    wr(2'd0, SEL_KICK, KEY);
    chk_out("win_early", 4'b0001, 1'b1);
    rd_check("win_early_status", 2'd0, SEL_STATUS, 32'd7);
    wr(2'd0, SEL_CTRL, 32'd0);
    chk_out("win_disable", 4'b0000, 1'b0);
    rd_check("win_cleared_status", 2'd0, SEL_STATUS, 32'd0);
    wr(2'd0, SEL_CTRL, 32'd3);
    idle(6);
    wr(2'd0, SEL_KICK, KEY);
    chk_out("win_late", 4'b0000, 1'b0);
    rd_check("win_late_status", 2'd0, SEL_STATUS, 32'd1);
    idle(9);
    chk_out("win_late_pre", 4'b0000, 1'b0);
    idle(1);
    chk_out("win_late_fire", 4'b0001, 1'b0);
    wr(2'd0, SEL_CTRL, 32'd0);

    // Bad key on ch1 is ignored; timeout still fires.
    wr(2'd1, SEL_TOCNT, 32'd2);
    wr(2'd1, SEL_CTRL, 32'd1);
    idle(1);
    wr(2'd1, SEL_KICK, BAD);
    chk_out("badkey_pre", 4'b0000, 1'b0);
    idle(1);
    chk_out("badkey_fire", 4'b0010, 1'b0);
    rd_check("badkey_status", 2'd1, SEL_STATUS, 32'hA);
    wr(2'd1, SEL_CTRL, 32'd0);

    // Valid kick on the exact timeout tick wins.
    wr(2'd1, SEL_CTRL, 32'd1);
    idle(2);
    wr(2'd1, SEL_KICK, KEY);
    chk_out("simul_kick", 4'b0000, 1'b0);
    rd_check("simul_status", 2'd1, SEL_STATUS, 32'd1);
    idle(2);
    chk_out("simul_pre", 4'b0000, 1'b0);
    idle(1);
    chk_out("simul_fire", 4'b0010, 1'b0);
    // Kick in STAGE1 returns to COUNT and drops irq.
    wr(2'd1, SEL_KICK, KEY);
    chk_out("stage1_kick", 4'b0000, 1'b0);
    rd_check("stage1_kick_status", 2'd1, SEL_STATUS, 32'd1);
    wr(2'd1, SEL_CTRL, 32'd0);

    // TOCNT=0 times out on the first tick.
    wr(2'd2, SEL_CTRL, 32'd1);
    chk_out("tocnt0_en", 4'b0000, 1'b0);
    idle(1);
    chk_out("tocnt0_fire", 4'b0100, 1'b0);
    wr(2'd2, SEL_CTRL, 32'd0);

    // Async reset mid-count on ch2/ch3 with ch0 fired.
    wr(2'd0, SEL_TOCNT, 32'd0);
    wr(2'd2, SEL_TOCNT, 32'd20);
    wr(2'd3, SEL_TOCNT, 32'd20);
    wr(2'd2, SEL_CTRL, 32'd1);
    wr(2'd3, SEL_CTRL, 32'd1);
    wr(2'd0, SEL_CTRL, 32'd5);
    idle(2);
    chk_out("prereset", 4'b0001, 1'b1);
    wr(2'd0, SEL_PRESC, 32'd3);
    #2;
    wdt_rst = 1'b0;
    #1;
    chk_out("async_assert", 4'b0000, 1'b0);
    @(negedge wdt_clk);
    wdt_rst = 1'b1;
    @(posedge wdt_clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      for (int s = 0; s < 5; s++) begin
        rd_check($sformatf("post_rst_ch%0d_sel%0d", c, s), 2'(c), 3'(s), 32'd0);
      end
    end
    rd_check("post_rst_presc", 2'd0, SEL_PRESC, 32'd0);
    idle(25);
    chk_out("post_rst_idle", 4'b0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
